mole_generator: RTL and testbench

Produces the whack-a-mole target for the scoring block: picks a pseudo-random 3-bit mole position, holds it visible for a tick-timed lifetime, then blanks it for a gap. Sits upstream of the score evaluator, driving its `mole_pos`/`mole_change` inputs and consuming its `guess_correct`/`guess_wrong` results. It also tracks misses, shortens the mole lifetime as the player scores, and ends the game on a miss limit.

---
 rtl/mole_if.sv | 38 +++
 rtl/mole_generator.sv | 174 +++++++++++++++++
 tb/tb_mole_generator.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mole_if.sv
// mole_if: signal bundle between the mole generator and the score evaluator /
// game controller. The generator uses the master modport and the peer uses the
// slave modport.
interface mole_if;
    logic       tick;
    logic       start;
    logic       guess_correct;
    logic       guess_wrong;
    logic [2:0] mole_pos;
    logic       mole_change;
    logic       mole_visible;
    logic [7:0] misses;
    logic       game_over;

    modport master (
        input  tick,
        input  start,
        input  guess_correct,
        input  guess_wrong,
        output mole_pos,
        output mole_change,
        output mole_visible,
        output misses,
        output game_over
    );

    modport slave (
        output tick,
        output start,
        output guess_correct,
        output guess_wrong,
        input  mole_pos,
        input  mole_change,
        input  mole_visible,
        input  misses,
        input  game_over
    );
endinterface

// File: rtl/mole_generator.sv
// mole_generator: whack-a-mole target source. An 8-bit LFSR picks a position
// that is never equal to the previous one. The mole is shown for a tick-timed
// lifetime and is then blanked for a gap. Hits shorten the lifetime down to a
// floor. Misses are counted, and the game ends when the count reaches the
// miss limit.
// Optional feature macro: MOLE_WRONG_PENALTY_EN. When it is defined, a rising
// edge of guess_wrong during SHOW counts as a miss.
module mole_generator #(
    parameter int unsigned TICKS_INIT = 20,
    parameter int unsigned TICKS_MIN  = 4,
    parameter int unsigned TICKS_STEP = 1,
    parameter int unsigned GAP_TICKS  = 3,
    parameter int unsigned MAX_MISSES = 5,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic   clk,
    input  logic   rst,
    mole_if.master bus
);
    typedef enum logic [1:0] {IDLE, SHOW, GAP, OVER} state_t;

    localparam logic [7:0] INIT_L = 8'(TICKS_INIT);
    localparam logic [7:0] MIN_L  = 8'(TICKS_MIN);
    localparam logic [7:0] STEP_L = 8'(TICKS_STEP);
    localparam logic [7:0] GAP_L  = 8'(GAP_TICKS);
    localparam logic [7:0] MAX_L  = 8'(MAX_MISSES);
    // Smallest lifetime that can take a full step and stay at or above the floor.
    localparam logic [8:0] SHRINK_LIMIT = 9'(TICKS_MIN) + 9'(TICKS_STEP);

    state_t     state_reg, state_next;
    logic [7:0] lfsr_reg;
    logic [2:0] pos_reg, pos_next;
    logic       change_reg, change_next;
    logic       visible_reg;
    logic       over_reg;
    logic [7:0] misses_reg, misses_next;
    logic [7:0] lifetime_reg, lifetime_next;
    logic [7:0] remain_reg, remain_next;
    logic       gc_prev_reg;

    logic       hit;
    logic       wrong_edge;
    logic       timeout;
    logic [2:0] cand;
    logic [2:0] new_pos;
    logic [7:0] misses_inc;
    logic [7:0] lifetime_short;

`ifdef MOLE_WRONG_PENALTY_EN
    logic gw_prev_reg;

    // Track guess_wrong so that only its rising edge is charged as a miss.
    always_ff @(posedge clk) begin
        if (!rst) begin
            gw_prev_reg <= 1'b0;
        end else begin
            gw_prev_reg <= bus.guess_wrong;
        end
    end

    assign wrong_edge = bus.guess_wrong & ~gw_prev_reg;
`else
    // guess_wrong has no effect in this build.
    logic unused_guess_wrong;
    assign unused_guess_wrong = bus.guess_wrong;
    assign wrong_edge         = 1'b0;
`endif

    assign hit     = bus.guess_correct & ~gc_prev_reg;
    assign timeout = bus.tick && (remain_reg == 8'd0);

    // The new position comes from the low LFSR bits. It is bumped by one if it
    // would repeat the current position.
    assign cand    = lfsr_reg[2:0];
    assign new_pos = (cand == pos_reg) ? cand + 3'd1 : cand;

    // The miss count saturates at the limit, so it cannot run past MAX_MISSES.
    assign misses_inc = (misses_reg < MAX_L) ? misses_reg + 8'd1 : misses_reg;

    // Shorten the lifetime by one step with a floor. The compare is done
    // before the subtraction so that the result never wraps below zero.
    assign lifetime_short = ({1'b0, lifetime_reg} >= SHRINK_LIMIT) ?
                            lifetime_reg - STEP_L : MIN_L;

    // Next-state and datapath decisions for the game sequencer.
    always_comb begin
        state_next    = state_reg;
        pos_next      = pos_reg;
        change_next   = 1'b0;
        misses_next   = misses_reg;
        lifetime_next = lifetime_reg;
        remain_next   = remain_reg;
        unique case (state_reg)
            IDLE, OVER: begin
                if (bus.start) begin
                    state_next    = SHOW;
                    pos_next      = new_pos;
                    change_next   = 1'b1;
                    misses_next   = 8'd0;
                    lifetime_next = INIT_L;
                    remain_next   = INIT_L - 8'd1;
                end
            end
            SHOW: begin
                if (hit) begin
                    // A hit takes priority over a timeout or wrong guess in the same cycle.
                    state_next    = GAP;
                    lifetime_next = lifetime_short;
                    remain_next   = GAP_L - 8'd1;
                end else if (timeout || wrong_edge) begin
                    misses_next = misses_inc;
                    state_next  = (misses_inc == MAX_L) ? OVER : GAP;
                    remain_next = GAP_L - 8'd1;
                end else if (bus.tick) begin
                    remain_next = remain_reg - 8'd1;
                end
            end
            GAP: begin
                if (bus.tick) begin
                    if (remain_reg == 8'd0) begin
                        state_next  = SHOW;
                        pos_next    = new_pos;
                        change_next = 1'b1;
                        remain_next = lifetime_reg - 8'd1;
                    end else begin
                        remain_next = remain_reg - 8'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers. Visible and game-over are registered from
    // the next state, so they change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            pos_reg      <= 3'd0;
            change_reg   <= 1'b0;
            visible_reg  <= 1'b0;
            over_reg     <= 1'b0;
            misses_reg   <= 8'd0;
            lifetime_reg <= INIT_L;
            remain_reg   <= 8'd0;
            gc_prev_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pos_reg      <= pos_next;
            change_reg   <= change_next;
            visible_reg  <= (state_next == SHOW);
            over_reg     <= (state_next == OVER);
            misses_reg   <= misses_next;
            lifetime_reg <= lifetime_next;
            remain_reg   <= remain_next;
            gc_prev_reg  <= bus.guess_correct;
        end
    end

    // Fibonacci LFSR with taps 8,6,5,4. It free-runs on every clock outside reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
        end
    end

    assign bus.mole_pos     = pos_reg;
    assign bus.mole_change  = change_reg;
    assign bus.mole_visible = visible_reg;
    assign bus.misses       = misses_reg;
    assign bus.game_over    = over_reg;
endmodule

// File: tb/tb_mole_generator.sv
// tb_mole_generator: table-driven bench for mole_generator, with
// TICKS_INIT=4, TICKS_MIN=2, TICKS_STEP=1, GAP_TICKS=2 and MAX_MISSES=3.
// Each table row is one clock. Hand sequences cover the long game-over hold
// and the wrong-guess penalty.
module tb_mole_generator;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    mole_if bus();

    mole_generator #(
        .TICKS_INIT(4),
        .TICKS_MIN (2),
        .TICKS_STEP(1),
        .GAP_TICKS (2),
        .MAX_MISSES(3),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic       rst_n;
        logic       start;
        logic       gc;
        logic       tick;
        logic       vis;
        logic       ch;
        logic [7:0] mis;
        logic       over;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   fails  = 0;
    logic [2:0] last_pos = 3'd0;

    // Reference LFSR. lfsr_prev holds the value the DUT used at the most recent edge.
    logic [7:0] lfsr_m;
    logic [7:0] lfsr_prev;
    always @(posedge clk) begin
        lfsr_prev <= lfsr_m;
        if (!rst) lfsr_m <= 8'hA5;
        else      lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    function automatic vec_t mk(logic r, logic s, logic g, logic t,
                                logic v, logic c, logic [7:0] m, logic o);
        vec_t x;
        x.rst_n = r; x.start = s; x.gc = g; x.tick = t;
        x.vis = v; x.ch = c; x.mis = m; x.over = o;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected position for a new mole: the LFSR candidate, bumped if it would repeat.
    function automatic logic [2:0] exp_new_pos(logic [7:0] l, logic [2:0] prev);
        logic [2:0] c;
        c = l[2:0];
        return (c == prev) ? c + 3'd1 : c;
    endfunction

    task automatic check_pos(input logic ch_expected, input logic was_reset);
        logic [2:0] e;
        if (was_reset) begin
            last_pos = 3'd0;
        end
        if (ch_expected) begin
            e = exp_new_pos(lfsr_prev, last_pos);
            check("pos_differs", {31'd0, bus.mole_pos != last_pos}, 32'd1);
            last_pos = e;
        end
        check("mole_pos", {29'd0, bus.mole_pos}, {29'd0, last_pos});
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            rst               = vecs[i].rst_n;
            bus.start         = vecs[i].start;
            bus.guess_correct = vecs[i].gc;
            bus.tick          = vecs[i].tick;
            @(posedge clk);
            #1;
            $display("vec %0d: rst=%0b start=%0b gc=%0b tick=%0b -> vis=%0b ch=%0b pos=%0d mis=%0d over=%0b",
                     i, vecs[i].rst_n, vecs[i].start, vecs[i].gc, vecs[i].tick,
                     bus.mole_visible, bus.mole_change, bus.mole_pos, bus.misses, bus.game_over);
            check($sformatf("vec%0d_visible", i), {31'd0, bus.mole_visible}, {31'd0, vecs[i].vis});
            check($sformatf("vec%0d_change", i),  {31'd0, bus.mole_change},  {31'd0, vecs[i].ch});
            check($sformatf("vec%0d_misses", i),  {24'd0, bus.misses},       {24'd0, vecs[i].mis});
            check($sformatf("vec%0d_over", i),    {31'd0, bus.game_over},    {31'd0, vecs[i].over});
            check_pos(vecs[i].ch, !vecs[i].rst_n);
        end
    endtask

    int split;

    initial begin
        bus.tick = 1'b0; bus.start = 1'b0; bus.guess_correct = 1'b0; bus.guess_wrong = 1'b0;

        // Part A: reset, timeout, hits that shrink the lifetime to its floor,
        // a hit that coincides with a timeout, and the run to game over.
        //            rst st gc tk  vis ch mis over
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 8'd0, 0)); // 0 reset
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 8'd0, 0)); // 1 idle
        vecs.push_back(mk(1, 1, 0, 1, 1, 1, 8'd0, 0)); // 2 start -> SHOW
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 8'd0, 0)); // 3
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 8'd0, 0)); // 4
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 8'd0, 0)); // 5 4th visible cycle
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 8'd1, 0)); // 6 timeout -> GAP
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 8'd1, 0)); // 7 gap
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 8'd1, 0)); // 8 new mole
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 8'd1, 0)); // 9 hit in 2nd cycle -> lifetime 3
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 8'd1, 0)); // 10 gap, gc held
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 8'd1, 0)); // 11 new mole
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 8'd1, 0)); // 12
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 8'd1, 0)); // 13 3rd visible cycle
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 8'd2, 0)); // 14 timeout
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 8'd2, 0)); // 15
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 8'd2, 0)); // 16 new mole (lifetime 3)
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 8'd2, 0)); // 17 hit -> lifetime 2
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 8'd2, 0)); // 18
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 8'd2, 0)); // 19 new mole (lifetime 2)
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 8'd2, 0)); // 20 hit -> stays at floor 2
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 8'd2, 0)); // 21
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 8'd2, 0)); // 22 new mole (lifetime 2)
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 8'd2, 0)); // 23 last visible cycle
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 8'd2, 0)); // 24 hit on timeout tick: hit wins
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 8'd2, 0)); // 25 start ignored in GAP
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 8'd2, 0)); // 26 new mole
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 8'd2, 0)); // 27 start ignored in SHOW
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 8'd3, 1)); // 28 third miss -> OVER
        split = vecs.size();
        // Part B: restart from OVER, a tick stall, reset mid-SHOW, and resume.
        vecs.push_back(mk(1, 1, 0, 1, 1, 1, 8'd0, 0)); // B0 restart, lifetime 4
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 8'd0, 0)); // B1 no tick: hold
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 8'd0, 0)); // B2
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 8'd0, 0)); // B3
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 8'd0, 0)); // B4
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 8'd1, 0)); // B5 timeout
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 8'd1, 0)); // B6
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 8'd1, 0)); // B7 lifetime back at 4
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 8'd1, 0)); // B8
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 8'd1, 0)); // B9
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 8'd1, 0)); // B10
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 8'd2, 0)); // B11 timeout
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 8'd2, 0)); // B12
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 8'd2, 0)); // B13 SHOW with misses=2
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 8'd0, 0)); // B14 reset mid-SHOW
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 8'd0, 0)); // B15 idle, waits for start
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 8'd0, 0)); // B16
        vecs.push_back(mk(1, 1, 0, 1, 1, 1, 8'd0, 0)); // B17 resume
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 8'd0, 0)); // B18

        run_vectors(0, split);

        // Game over must hold for 50 cycles with no new mole.
        @(negedge clk);
        bus.start = 1'b0;
        bus.guess_correct = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            $display("over hold %0d: vis=%0b ch=%0b mis=%0d over=%0b",
                     c, bus.mole_visible, bus.mole_change, bus.misses, bus.game_over);
            check("over_change", {31'd0, bus.mole_change}, 32'd0);
            check("over_flag", {31'd0, bus.game_over}, 32'd1);
            check("over_visible", {31'd0, bus.mole_visible}, 32'd0);
            check("over_misses", {24'd0, bus.misses}, 32'd3);
        end

        run_vectors(split, vecs.size());

        // Wrong-guess rising edge in SHOW.
        @(negedge clk);
        bus.guess_wrong = 1'b1;
        @(posedge clk);
        #1;
        $display("wrong guess: vis=%0b ch=%0b mis=%0d over=%0b",
                 bus.mole_visible, bus.mole_change, bus.misses, bus.game_over);
`ifdef MOLE_WRONG_PENALTY_EN
        check("wrong_visible", {31'd0, bus.mole_visible}, 32'd0);
        check("wrong_misses", {24'd0, bus.misses}, 32'd1);
`else
        check("wrong_visible", {31'd0, bus.mole_visible}, 32'd1);
        check("wrong_misses", {24'd0, bus.misses}, 32'd0);
`endif
        @(posedge clk);
        #1;
        $display("wrong guess +1: vis=%0b ch=%0b mis=%0d over=%0b",
                 bus.mole_visible, bus.mole_change, bus.misses, bus.game_over);
`ifdef MOLE_WRONG_PENALTY_EN
        check("wrong_hold_visible", {31'd0, bus.mole_visible}, 32'd0);
        check("wrong_hold_misses", {24'd0, bus.misses}, 32'd1);
`else
        check("wrong_hold_visible", {31'd0, bus.mole_visible}, 32'd1);
        check("wrong_hold_misses", {24'd0, bus.misses}, 32'd0);
`endif
        check("wrong_change", {31'd0, bus.mole_change}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
